// File: rtl/bcd_pkg.sv
// Shared packed-BCD helpers: digit constants, validity test and step-mask generation.
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam int         BCD_MAX_DIGITS = 8;

    // Only the lowest `digits` nibbles of vec are inspected.
    function automatic logic bcd_valid(input logic [31:0] vec, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && vec[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // One-hot digit mask for a step of 10^step_dig; out-of-range selects the units digit.
    function automatic logic [7:0] pow10_onehot(input int step_dig, input int digits);
        logic [7:0] mask;
        if (step_dig >= 0 && step_dig < digits) begin
            mask = 8'd1 << step_dig;
        end else begin
            mask = 8'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_range_counter_if.sv
// Control/status bundle of the BCD range counter; master drives requests, slave is the counter.
interface bcd_range_counter_if #(
    parameter int DIGITS = 2
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic          inc_pulse;
    logic          dec_pulse;
    logic [SW-1:0] step_dig;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  value;
    logic          at_min;
    logic          at_max;
    logic          changed;
    logic          wrapped;
    logic          load_err;

    modport master (
        output inc_pulse, dec_pulse, step_dig, load, load_val,
        input  value, at_min, at_max, changed, wrapped, load_err
    );

    modport slave (
        input  inc_pulse, dec_pulse, step_dig, load, load_val,
        output value, at_min, at_max, changed, wrapped, load_err
    );

endinterface

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of the shared add/subtract ripple: adds or subtracts the incoming carry/borrow.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    input  logic                   i_add_one,
    input  logic                   i_sub_one,
    input  logic                   i_cbin,
    output logic [BCD_DIGIT_W-1:0] o_digit,
    output logic                   o_cbout
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        o_digit = i_digit;
        o_cbout = 1'b0;
        if (i_cbin && i_add_one) begin
            if (i_digit >= BCD_MAX_DIGIT) begin
                o_digit = '0;
                o_cbout = 1'b1;
            end else begin
                o_digit = i_digit + 4'd1;
            end
        end else if (i_cbin && i_sub_one) begin
            if (i_digit == '0) begin
                o_digit = BCD_MAX_DIGIT;
                o_cbout = 1'b1;
            end else begin
                o_digit = i_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_range_counter.sv
// N-digit packed-BCD up/down counter with MIN..MAX range, wrap/saturate, step digit and load.
module bcd_range_counter
    import bcd_pkg::*;
#(
    parameter int                  DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] MIN_VAL  = 'h00,
    parameter logic [4*DIGITS-1:0] MAX_VAL  = 'h99,
    parameter logic [4*DIGITS-1:0] INIT_VAL = 'h50,
    parameter bit                  WRAP     = 1'b1
) (
    input logic               clk,
    input logic               rst,
    bcd_range_counter_if.slave bus
);

    localparam int W = 4 * DIGITS;

    generate
        if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS ||
            !bcd_valid(32'(MIN_VAL), DIGITS) || !bcd_valid(32'(MAX_VAL), DIGITS) ||
            !bcd_valid(32'(INIT_VAL), DIGITS) ||
            MIN_VAL > INIT_VAL || INIT_VAL > MAX_VAL) begin : g_param_err
            $error("bcd_range_counter: illegal DIGITS/MIN_VAL/INIT_VAL/MAX_VAL combination");
        end
    endgenerate

    logic [W-1:0]      r_value;
    logic              r_at_min;
    logic              r_at_max;
    logic              r_changed;
    logic              r_wrapped;
    logic              r_load_err;

    logic              w_do_inc;
    logic              w_do_dec;
    logic [DIGITS-1:0] w_mask;
    logic [DIGITS-1:0] w_cin;
    logic [DIGITS-1:0] w_cout;
    logic [W-1:0]      w_res;
    logic [W-1:0]      w_next;
    logic              w_wrap;
    logic              w_lerr;

    // Simultaneous inc and dec cancel, so the chain only ever runs in one direction.
    assign w_do_inc = bus.inc_pulse & ~bus.dec_pulse;
    assign w_do_dec = bus.dec_pulse & ~bus.inc_pulse;
    assign w_mask   = DIGITS'(pow10_onehot(int'(bus.step_dig), DIGITS));

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign w_cin[i] = w_mask[i];
        end else begin : g_upper
            assign w_cin[i] = w_mask[i] | w_cout[i-1];
        end

        bcd_digit_addsub u_digit (
            .i_digit   (r_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .i_add_one (w_do_inc),
            .i_sub_one (w_do_dec),
            .i_cbin    (w_cin[i]),
            .o_digit   (w_res[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_cbout   (w_cout[i])
        );
    end

    always_comb begin
        w_next = r_value;
        w_wrap = 1'b0;
        w_lerr = 1'b0;
        if (bus.load) begin
            if (!bcd_valid(32'(bus.load_val), DIGITS)) begin
                w_lerr = 1'b1;
            end else if (bus.load_val < MIN_VAL) begin
                w_next = MIN_VAL;
            end else if (bus.load_val > MAX_VAL) begin
                w_next = MAX_VAL;
            end else begin
                w_next = bus.load_val;
            end
        end else if (w_do_inc) begin
            if (w_cout[DIGITS-1] || w_res > MAX_VAL) begin
                w_wrap = 1'b1;
                w_next = WRAP ? MIN_VAL : MAX_VAL;
            end else begin
                w_next = w_res;
            end
        end else if (w_do_dec) begin
            if (w_cout[DIGITS-1] || w_res < MIN_VAL) begin
                w_wrap = 1'b1;
                w_next = WRAP ? MAX_VAL : MIN_VAL;
            end else begin
                w_next = w_res;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value    <= INIT_VAL;
            r_at_min   <= (INIT_VAL == MIN_VAL);
            r_at_max   <= (INIT_VAL == MAX_VAL);
            r_changed  <= 1'b0;
            r_wrapped  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_value    <= w_next;
            r_at_min   <= (w_next == MIN_VAL);
            r_at_max   <= (w_next == MAX_VAL);
            r_changed  <= (w_next != r_value);
            r_wrapped  <= w_wrap;
            r_load_err <= w_lerr;
        end
    end

    assign bus.value    = r_value;
    assign bus.at_min   = r_at_min;
    assign bus.at_max   = r_at_max;
    assign bus.changed  = r_changed;
    assign bus.wrapped  = r_wrapped;
    assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Drives three counter configurations with directed and random requests against a decimal model.
module tb_bcd_range_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_range_counter_if #(.DIGITS(2)) bus_a ();
    bcd_range_counter_if #(.DIGITS(2)) bus_b ();
    bcd_range_counter_if #(.DIGITS(3)) bus_c ();

    bcd_range_counter #(.DIGITS(2)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    bcd_range_counter #(
        .DIGITS(2), .MIN_VAL(8'h10), .MAX_VAL(8'h90), .INIT_VAL(8'h50), .WRAP(1'b0)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    bcd_range_counter #(
        .DIGITS(3), .MIN_VAL(12'h000), .MAX_VAL(12'h999), .INIT_VAL(12'h195), .WRAP(1'b1)
    ) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_checks = 0;
    int n_pass   = 0;

    // Model configurations held as plain decimal integers.
    int    cfg_digits[3] = '{2, 2, 3};
    int    cfg_min[3]    = '{0, 10, 0};
    int    cfg_max[3]    = '{99, 90, 999};
    int    cfg_init[3]   = '{50, 50, 195};
    bit    cfg_wrap[3]   = '{1'b1, 1'b0, 1'b1};
    string cfg_name[3]   = '{"a", "b", "c"};

    int m_val[3];
    bit m_changed[3];
    bit m_wrapped[3];
    bit m_lerr[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] int2bcd(input int n);
        logic [31:0] r;
        int          t;
        r = '0;
        t = n;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [31:0] v, input int d);
        int n;
        n = 0;
        for (int i = d - 1; i >= 0; i--) begin
            n = n * 10 + int'(v[4*i +: 4]);
        end
        return n;
    endfunction

    function automatic bit bcd_ok(input logic [31:0] v, input int d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < d; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic void model_step(input int k, input bit r, input bit inc, input bit dec,
                                       input int step, input bit ld, input logic [31:0] lval);
        int d;
        int old;
        int nv;
        int p;
        int t;
        d   = cfg_digits[k];
        old = m_val[k];
        nv  = old;
        m_wrapped[k] = 1'b0;
        m_lerr[k]    = 1'b0;
        if (r) begin
            nv = cfg_init[k];
        end else if (ld) begin
            if (!bcd_ok(lval, d)) begin
                m_lerr[k] = 1'b1;
            end else begin
                t  = bcd2int(lval, d);
                nv = (t < cfg_min[k]) ? cfg_min[k] : (t > cfg_max[k]) ? cfg_max[k] : t;
            end
        end else if (inc != dec) begin
            p = 1;
            if (step < d) begin
                for (int i = 0; i < step; i++) p = p * 10;
            end
            if (inc) begin
                t = old + p;
                if (t > cfg_max[k]) begin
                    m_wrapped[k] = 1'b1;
                    nv = cfg_wrap[k] ? cfg_min[k] : cfg_max[k];
                end else begin
                    nv = t;
                end
            end else begin
                t = old - p;
                if (t < cfg_min[k]) begin
                    m_wrapped[k] = 1'b1;
                    nv = cfg_wrap[k] ? cfg_max[k] : cfg_min[k];
                end else begin
                    nv = t;
                end
            end
        end
        m_changed[k] = !r && (nv != old);
        m_val[k]     = nv;
    endfunction

    task automatic check_dut(input int k, input logic [31:0] val, input logic amin,
                             input logic amax, input logic ch, input logic wr, input logic le);
        check({cfg_name[k], ".value"},    val,       int2bcd(m_val[k]));
        check({cfg_name[k], ".at_min"},   32'(amin), 32'(m_val[k] == cfg_min[k]));
        check({cfg_name[k], ".at_max"},   32'(amax), 32'(m_val[k] == cfg_max[k]));
        check({cfg_name[k], ".changed"},  32'(ch),   32'(m_changed[k]));
        check({cfg_name[k], ".wrapped"},  32'(wr),   32'(m_wrapped[k]));
        check({cfg_name[k], ".load_err"}, 32'(le),   32'(m_lerr[k]));
    endtask

    // Apply one cycle of requests to all three counters, then compare against the model.
    task automatic cycle(input bit r, input bit inc, input bit dec, input int step,
                         input bit ld, input logic [31:0] lval);
        rst = r;
        bus_a.inc_pulse = inc; bus_a.dec_pulse = dec; bus_a.load = ld;
        bus_b.inc_pulse = inc; bus_b.dec_pulse = dec; bus_b.load = ld;
        bus_c.inc_pulse = inc; bus_c.dec_pulse = dec; bus_c.load = ld;
        bus_a.step_dig = 1'(step);
        bus_b.step_dig = 1'(step);
        bus_c.step_dig = 2'(step);
        bus_a.load_val = lval[7:0];
        bus_b.load_val = lval[7:0];
        bus_c.load_val = lval[11:0];
        @(posedge clk);
        #1;
        model_step(0, r, inc, dec, step & 1, ld, {24'd0, lval[7:0]});
        model_step(1, r, inc, dec, step & 1, ld, {24'd0, lval[7:0]});
        model_step(2, r, inc, dec, step & 3, ld, {20'd0, lval[11:0]});
        check_dut(0, 32'(bus_a.value), bus_a.at_min, bus_a.at_max,
                  bus_a.changed, bus_a.wrapped, bus_a.load_err);
        check_dut(1, 32'(bus_b.value), bus_b.at_min, bus_b.at_max,
                  bus_b.changed, bus_b.wrapped, bus_b.load_err);
        check_dut(2, 32'(bus_c.value), bus_c.at_min, bus_c.at_max,
                  bus_c.changed, bus_c.wrapped, bus_c.load_err);
    endtask

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) m_val[k] = 0;

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
        check("plan.reset_a", 32'(bus_a.value), 32'h50);
        check("plan.reset_a_min", 32'(bus_a.at_min), 32'h0);

        // Default counter: count up to the top, then wrap to zero.
        repeat (49) cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.a_top", 32'(bus_a.value), 32'h99);
        check("plan.a_at_max", 32'(bus_a.at_max), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.a_wrap", 32'(bus_a.value), 32'h00);
        check("plan.a_wrapped", 32'(bus_a.wrapped), 32'h1);

        // Saturating counter with coarse step.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h088);
        cycle(1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        check("plan.b_sat", 32'(bus_b.value), 32'h90);
        check("plan.b_sat_wrapped", 32'(bus_b.wrapped), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        check("plan.b_sat_hold_changed", 32'(bus_b.changed), 32'h0);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 1, 1'b0, 32'h0);
        check("plan.b_floor", 32'(bus_b.value), 32'h10);

        // Three-digit carries and borrows.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h195);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.c_196", 32'(bus_c.value), 32'h196);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h199);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.c_200", 32'(bus_c.value), 32'h200);
        cycle(1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        check("plan.c_199", 32'(bus_c.value), 32'h199);

        // Cancelling pulses and load priority.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h050);
        cycle(1'b0, 1'b1, 1'b1, 0, 1'b0, 32'h0);
        check("plan.a_both_pulses", 32'(bus_a.value), 32'h50);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b1, 32'h033);
        check("plan.a_load_wins", 32'(bus_a.value), 32'h33);

        // Rejected and clamped loads.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h03A);
        check("plan.a_load_err", 32'(bus_a.load_err), 32'h1);
        check("plan.a_load_keep", 32'(bus_a.value), 32'h33);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h005);
        check("plan.b_load_clamp", 32'(bus_b.value), 32'h10);

        // Back-to-back pulses with reset landing on the third.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h050);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.a_mid_reset", 32'(bus_a.value), 32'h50);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0);
        check("plan.a_after_reset", 32'(bus_a.value), 32'h52);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 11) == 0, rand_bcd());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
